// File: rtl/range_seq_pkg.sv
// Shared types and constants for the range-finder sequencer.
package range_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int WIDTH_DEF    = 10;
  localparam int CNT_W_DEF    = 8;
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/range_sequencer.sv
// Frames fixed-length windows from a gappy sample stream, drives the range finder's go/finish/data
// pins and holds the captured range plus sticky error on a valid/ready result port.
module range_sequencer
  import range_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [CNT_W-1:0] win_len,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic [WIDTH-1:0] result,
  output logic             result_error,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             drop
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;
  logic             rf_go_q, rf_go_d;
  logic             rf_finish_q, rf_finish_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_error_q, result_error_d;
  logic             err_q, err_d;
  logic [1:0]       drain_q, drain_d;
  logic             drop_q, drop_d;
  logic             rearm;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    rf_data_d      = rf_data_q;
    rf_go_d        = 1'b0;
    rf_finish_d    = 1'b0;
    result_d       = result_q;
    result_error_d = result_error_q;
    err_d          = err_q;
    drain_d        = drain_q;
    rearm          = 1'b0;
    drop_d         = sample_valid && (state_q inside {IDLE, DRAIN, HOLD});

    // Finder is open from the go cycle through capture; any error in that span sticks.
    if (state_q inside {RUN, DRAIN}) begin
      err_d = err_q | rf_error;
    end

    if (abort) begin
      if (state_q == RUN) begin
        rf_finish_d = 1'b1;
        rf_data_d   = last_q;
      end
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          rearm = start;
        end
        ARM: begin
          if (sample_valid) begin
            rf_go_d   = 1'b1;
            rf_data_d = sample_in;
            last_d    = sample_in;
            cnt_d     = CNT_W'(1);
            state_d   = RUN;
          end
        end
        RUN: begin
          // Repeating the last seen value during gaps leaves max-min unchanged.
          rf_data_d = sample_valid ? sample_in : last_q;
          if (sample_valid) begin
            last_d = sample_in;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == len_q - CNT_W'(1)) begin
              rf_finish_d = 1'b1;
              drain_d     = 2'd0;
              state_d     = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
            result_d       = rf_range;
            result_error_d = err_q | rf_error;
            state_d        = HOLD;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            state_d = IDLE;
            rearm   = continuous;
          end
        end
        default: state_d = IDLE;
      endcase

      // Windows shorter than two samples never open the finder and report a zero range.
      if (rearm) begin
        len_d = win_len;
        if (win_len >= CNT_W'(2)) begin
          err_d   = 1'b0;
          state_d = ARM;
        end else begin
          result_d       = '0;
          result_error_d = 1'b0;
          state_d        = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      last_q         <= '0;
      rf_data_q      <= '0;
      rf_go_q        <= 1'b0;
      rf_finish_q    <= 1'b0;
      result_q       <= '0;
      result_error_q <= 1'b0;
      err_q          <= 1'b0;
      drain_q        <= 2'd0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      rf_data_q      <= rf_data_d;
      rf_go_q        <= rf_go_d;
      rf_finish_q    <= rf_finish_d;
      result_q       <= result_d;
      result_error_q <= result_error_d;
      err_q          <= err_d;
      drain_q        <= drain_d;
      drop_q         <= drop_d;
    end
  end

  assign rf_data      = rf_data_q;
  assign rf_go        = rf_go_q;
  assign rf_finish    = rf_finish_q;
  assign result       = result_q;
  assign result_error = result_error_q;
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign drop         = drop_q;

endmodule
